// File: rtl/tv80_alu16_seq.sv
// Two-cycle 16-bit add/subtract sequencer that drives the TV80 8-bit ALU.
// It runs the low byte first, then the high byte with the carry from the low byte.
module tv80_alu16_seq #(
  parameter int Flag_C = 4,
  parameter int Flag_H = 5,
  parameter int Flag_N = 6,
  parameter int Flag_Z = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cen,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f,
  output logic        alu_arith16,
  output logic        alu_z16,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_res
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_ADC = 2'b01, OP_SBC = 2'b10, OP_SUB = 2'b11} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [7:0]  fin_q, fin_d;
  logic [7:0]  flag_q, flag_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  f_out_q, f_out_d;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    fin_d    = fin_q;
    flag_d   = flag_q;
    result_d = result_q;
    f_out_d  = f_out_q;
    if (cen) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LO;
            op_d    = op_e'(op);
            opa_d   = opa;
            opb_d   = opb;
            fin_d   = f_in;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LO: begin
          result_d[7:0] = alu_q;
          flag_d        = alu_f_res;
          state_d       = S_HI;
        end
        S_HI: begin
          result_d[15:8]  = alu_q;
          f_out_d         = '0;
          f_out_d[Flag_Z] = alu_f_res[Flag_Z];
          f_out_d[Flag_N] = alu_f_res[Flag_N];
          f_out_d[Flag_H] = alu_f_res[Flag_H];
          f_out_d[Flag_C] = alu_f_res[Flag_C];
          state_d         = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      fin_q    <= '0;
      flag_q   <= '0;
      result_q <= '0;
      f_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      fin_q    <= fin_d;
      flag_q   <= flag_d;
      result_q <= result_d;
      f_out_q  <= f_out_d;
    end
  end

  // The low byte of SBC consumes the incoming carry, and the low byte of SUB does not.
  // The high byte always chains the carry from the low byte.
  always_comb begin
    alu_op      = 4'b0000;
    alu_busa    = '0;
    alu_busb    = '0;
    alu_f       = '0;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    case (state_q)
      S_LO: begin
        alu_busa    = opa_q[7:0];
        alu_busb    = opb_q[7:0];
        alu_f       = fin_q;
        alu_arith16 = (op_q == OP_ADD);
        case (op_q)
          OP_ADD:  alu_op = 4'b0000;
          OP_ADC:  alu_op = 4'b0001;
          OP_SBC:  alu_op = 4'b0011;
          default: alu_op = 4'b0010;
        endcase
      end
      S_HI: begin
        alu_busa    = opa_q[15:8];
        alu_busb    = opb_q[15:8];
        alu_f       = flag_q;
        alu_arith16 = (op_q == OP_ADD);
        alu_z16     = (op_q != OP_ADD);
        alu_op      = (op_q == OP_ADD || op_q == OP_ADC) ? 4'b0001 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == S_LO) || (state_q == S_HI);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign f_out  = f_out_q;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: a behavioural Game Boy 8-bit ALU stands in for the real one.
// Directed operations push their expected results, and a monitor checks each done pulse.
module tb_tv80_alu16_seq;

  typedef struct packed {
    logic [15:0] res;
    logic [7:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  logic [7:0]  f_in = '0;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic [7:0]  alu_busa, alu_busb, alu_f;
  logic        alu_arith16, alu_z16;
  logic [7:0]  alu_q, alu_f_res;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pushed = 0;
  int   n_done   = 0;
  logic done_prev = 1'b0;

  tv80_alu16_seq dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .start(start), .op(op),
    .opa(opa), .opb(opb), .f_in(f_in), .busy(busy), .done(done),
    .result(result), .f_out(f_out), .alu_op(alu_op), .alu_busa(alu_busa),
    .alu_busb(alu_busb), .alu_f(alu_f), .alu_arith16(alu_arith16),
    .alu_z16(alu_z16), .alu_q(alu_q), .alu_f_res(alu_f_res)
  );

  always #5 clk = ~clk;

  // Game Boy ALU subset: ADD/ADC/SUB/SBC, with Z=7, N=6, H=5 and C=4.
  function automatic logic [15:0] alu_model(input logic [3:0] aop, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] f,
                                            input logic ar16, input logic z16);
    logic       cin;
    logic [4:0] lo;
    logic [8:0] full;
    logic [7:0] q, fo;
    cin = aop[0] & f[4];
    fo  = 8'h00;
    if (!aop[1]) begin
      lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
      full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    end else begin
      lo    = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
      full  = {1'b0, a} - {1'b0, b} - {8'b0, cin};
      fo[6] = 1'b1;
    end
    fo[5] = lo[4];
    fo[4] = full[8];
    q     = full[7:0];
    fo[7] = (q == 8'h00) ? (z16 ? f[7] : 1'b1) : 1'b0;
    if (ar16) fo[7] = f[7];
    return {q, fo};
  endfunction

  always_comb {alu_q, alu_f_res} = alu_model(alu_op, alu_busa, alu_busb, alu_f, alu_arith16, alu_z16);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns with the DUT in its LO cycle.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] f, input logic [15:0] er, input logic [7:0] ef,
                       input bit push);
    op = o; opa = a; opb = b; f_in = f; start = 1'b1;
    if (push) begin
      exp_q.push_back({er, ef});
      n_pushed++;
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      step();
    end
    check(name, {31'b0, done}, 32'd1);
  endtask

  // Monitor: compare against the scoreboard once per DONE occurrence.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_without_request: got result %h f_out %h expected no done", result, f_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", {16'b0, result}, {16'b0, e.res});
        check("sb_f_out", {24'b0, f_out}, {24'b0, e.f});
      end
    end
    done_prev = done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    step(); step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {16'b0, result}, 32'h0);
    check("rst_f_out", {24'b0, f_out}, 32'h0);
    check("rst_alu_drive", {12'b0, alu_op, alu_busa, alu_busb}, 32'h0);
    check("rst_alu_f_flags", {22'b0, alu_f, alu_arith16, alu_z16}, 32'h0);
    reset_n = 1'b1;
    step();

    // ADD 0FFF+0001: expect done exactly three edges after start is sampled
    issue(2'b00, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0, 1'b1);
    check("add_lo_busy", {31'b0, busy}, 32'd1);
    check("add_lo_alu_op", {28'b0, alu_op}, 32'h0);
    check("add_lo_arith16", {30'b0, alu_arith16, alu_z16}, 32'h2);
    check("add_lo_buses", {16'b0, alu_busa, alu_busb}, 32'hFF01);
    check("add_lo_alu_f", {24'b0, alu_f}, 32'h80);
    step();
    check("add_hi_alu_op", {28'b0, alu_op}, 32'h1);
    check("add_hi_busa", {24'b0, alu_busa}, 32'h0F);
    check("add_hi_alu_f", {24'b0, alu_f}, 32'hB0);
    step();
    check("add_latency_done", {31'b0, done}, 32'd1);
    check("add_done_busy", {31'b0, busy}, 32'd0);
    step();
    check("add_idle_done", {31'b0, done}, 32'd0);

    // SBC 1000-0001; start and operand changes while busy must be ignored
    issue(2'b10, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h60, 1'b1);
    check("sbc_lo_alu_op", {28'b0, alu_op}, 32'h3);
    check("sbc_lo_z16", {31'b0, alu_z16}, 32'd0);
    start = 1'b1; op = 2'b00; opa = 16'hFFFF; opb = 16'hFFFF; f_in = 8'hFF;
    step();
    check("sbc_hi_alu_f", {24'b0, alu_f}, 32'h70);
    check("sbc_hi_buses", {16'b0, alu_busa, alu_busb}, 32'h1000);
    check("sbc_hi_alu_op", {28'b0, alu_op}, 32'h3);
    check("sbc_hi_z16", {31'b0, alu_z16}, 32'd1);
    start = 1'b0;
    step();
    check("sbc_done", {31'b0, done}, 32'd1);
    step();
    check("sbc_no_relaunch", {31'b0, busy}, 32'd0);

    // SUB to zero, then ADC wrapping to zero with carry out
    issue(2'b11, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'hC0, 1'b1);
    wait_done("sub_done");
    step();
    issue(2'b01, 16'hFFFF, 16'h0000, 8'h10, 16'h0000, 8'hB0, 1'b1);
    wait_done("adc_done");
    step();

    // cen=0 for three cycles during HI freezes everything
    issue(2'b00, 16'h00F8, 16'h0008, 8'h00, 16'h0100, 8'h00, 1'b1);
    step();
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_busy", {31'b0, busy}, 32'd1);
      check("frz_done", {31'b0, done}, 32'd0);
      check("frz_alu_f", {24'b0, alu_f}, 32'h30);
      check("frz_alu_op", {28'b0, alu_op}, 32'h1);
    end
    cen = 1'b1;
    step();
    check("frz_done_late", {31'b0, done}, 32'd1);

    // Back-to-back: start in the DONE cycle goes straight to LO
    issue(2'b11, 16'h0100, 16'h0001, 8'h00, 16'h00FF, 8'h40, 1'b1);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_alu_op", {28'b0, alu_op}, 32'h2);
    check("b2b_buses", {16'b0, alu_busa, alu_busb}, 32'h0001);
    wait_done("b2b_done");
    step();

    // Reset during HI aborts the operation and clears the outputs
    issue(2'b00, 16'h1111, 16'h1111, 8'h00, 16'h0000, 8'h00, 1'b0);
    step();
    reset_n = 1'b0;
    step();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", {16'b0, result}, 32'h0);
    check("abort_f_out", {24'b0, f_out}, 32'h0);
    check("abort_alu_op", {28'b0, alu_op}, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("abort_no_done", {31'b0, done}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    check("sb_done_count", n_done, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tv80_alu16_seq.md
# tv80_alu16_seq

Two-cycle 16-bit arithmetic sequencer for the Game Boy (Mode 3) TV80 core. It accepts a 16-bit operation request, then drives the existing 8-bit ALU across two consecutive cycles: low byte first, then high byte with the captured carry. It returns the 16-bit result and Game Boy flags through a start/busy/done handshake. It sits between the core's register-pair datapath and the 8-bit ALU, acting as the initiator the ALU responds to.

## Interface
Parameters:
- Flag_C, 4, carry bit position in F
- Flag_H, 5, half-carry bit position
- Flag_N, 6, subtract bit position
- Flag_Z, 7, zero bit position

Ports:
- clk  in  1  clock; one clock domain
- reset_n  in  1  reset, synchronous, active-low
- cen  in  1  clock enable; state and registers advance only when 1
- start  in  1  request; accepted on a cen cycle while busy=0
- op  in  2  00 ADD, 01 ADC, 10 SBC, 11 SUB
- opa  in  16  first operand
- opb  in  16  second operand
- f_in  in  8  flags at request time
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when result/f_out are valid
- result  out  16  16-bit result; held until the next done
- f_out  out  8  resulting flags; bits [3:0] always 0
- alu_op  out  4  to ALU ALU_Op
- alu_busa  out  8  to ALU BusA
- alu_busb  out  8  to ALU BusB
- alu_f  out  8  to ALU F_In
- alu_arith16  out  1  to ALU Arith16
- alu_z16  out  1  to ALU Z16
- alu_q  in  8  from ALU Q
- alu_f_res  in  8  from ALU F_Out

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE/DONE with cen=1 and start=1: latch op, opa, opb, f_in, then go to LO. Otherwise DONE goes to IDLE and IDLE stays in IDLE.
- LO state drives:
  - alu_busa=opa[7:0], alu_busb=opb[7:0], alu_f=latched f_in.
  - alu_op: ADD 0000, ADC 0001, SBC 0011, SUB 0010.
  - alu_z16=0. alu_arith16=1 for ADD only.
- LO with cen: result[7:0]←alu_q, flag latch←alu_f_res, then go to HI.
- HI state drives:
  - alu_busa=opa[15:8], alu_busb=opb[15:8], alu_f=flag latch.
  - alu_op: ADD/ADC 0001, SBC/SUB 0011.
  - alu_arith16=1 for ADD. alu_z16=1 for ADC/SBC/SUB, so Z=1 only if both bytes are zero.
- HI with cen: result[15:8]←alu_q, f_out←{alu_f_res[7:4],4'b0}, then go to DONE.
- Flag semantics: ADD preserves Z; N, H (bit 11) and C (bit 15) come from the ALU. ADC/SBC/SUB produce full Z, N, H, C.
- In IDLE/DONE, ALU drive outputs are 0: alu_op=0000, buses 0, alu_f 0, arith16/z16 0.
- Outputs are combinational from state and latches; result/f_out are registered.
- start while busy=1 is ignored. Operands are not re-sampled mid-operation.

## Timing
- Reset (reset_n=0 at a clk edge, regardless of cen): state=IDLE; busy=0, done=0, result=0000, f_out=00; ALU drive outputs 0.
- Reset asserted in LO/HI/DONE aborts the operation. done is not asserted and result/f_out clear to 0.
- Latency with cen held 1: start sampled at edge n; LO during cycle n+1; HI during n+2; done=1 and result valid during n+3.
- busy=1 exactly in LO and HI. done=1 exactly in DONE.
- Back-to-back: start=1 in the DONE cycle is accepted. The next LO follows immediately, with no IDLE gap.
- cen=0 freezes state, latches, done and busy; ALU drives stay stable. done lasts as long as the DONE state is held.
- result and f_out are unchanged outside the LO/HI capture edges.

## Test plan
- ADD, opa=0FFF, opb=0001, f_in=80 -> result=1000, f_out=A0 (Z kept, H=1, C=0), done at n+3.
- SBC, opa=1000, opb=0001, f_in=00 -> result=0FFF, f_out=60. Check the LO-cycle alu_op=0011 and the HI-cycle alu_f carrying C=1.
- SUB, opa=1234, opb=1234, f_in=00 -> result=0000, f_out=C0. Then ADC, opa=FFFF, opb=0000, f_in=10 -> result=0000, f_out=B0.
- Set cen=0 for 3 cycles during HI -> state/outputs frozen and done delayed 3 cycles. Then start=1 held during DONE -> second op accepted immediately with correct result.
- reset_n=0 during HI -> next cycle busy=0, result=0000, f_out=00, no done pulse. Also check start pulses while busy are ignored (operands unchanged).
